// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: repeat FSM states,
// button index constants and channel count.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  localparam int unsigned NUM_BTN = 5;

  localparam int unsigned U = 0;
  localparam int unsigned L = 1;
  localparam int unsigned C = 2;
  localparam int unsigned R = 3;
  localparam int unsigned D = 4;

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchronizer, tick-sampled debouncer with
// registered press pulse, and an IDLE/DELAY/REPEAT auto-repeat FSM.
module btn_chan
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 20,
  parameter int unsigned REPEAT_DLY = 500,
  parameter int unsigned REPEAT_PER = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic tick,
  output logic lvl,
  output logic prs,
  output logic rep
);

  localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [7:0]    STB_LAST = 8'(STABLE_CNT - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

  logic          sync1;
  logic          sync2;
  logic [7:0]    scnt;
  logic          accept;
  rep_state_t    state;
  rep_state_t    state_nxt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;
  logic          rep_nxt;

  // Level flips on this tick: synchronized input has differed for STABLE_CNT ticks
  always_comb accept = tick && (sync2 != lvl) && (scnt == STB_LAST);

  // Two-flop synchronizer for the raw asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debouncer: count consecutive differing ticks, flip level and pulse on press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
      lvl  <= 1'b0;
      prs  <= 1'b0;
    end else begin
      prs <= 1'b0;
      if (tick) begin
        if (sync2 != lvl) begin
          if (scnt == STB_LAST) begin
            scnt <= '0;
            lvl  <= ~lvl;
            prs  <= ~lvl;
          end else begin
            scnt <= scnt + 8'd1;
          end
        end else begin
          scnt <= '0;
        end
      end
    end
  end

  // Repeat FSM state, tick counter and registered repeat pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
      rep   <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      rep   <= rep_nxt;
    end
  end

  // Repeat FSM next state: level edges take priority over tick counting, so a
  // release on a repeat-due tick issues no pulse
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rep_nxt   = 1'b0;
    if (accept && !lvl) begin
      state_nxt = DELAY;
      rcnt_nxt  = '0;
      rep_nxt   = 1'b1;
    end else if (accept && lvl) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end else if (tick) begin
      case (state)
        DELAY: begin
          if (rcnt == DLY_LAST) begin
            state_nxt = REPEAT;
            rcnt_nxt  = '0;
            rep_nxt   = 1'b1;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
        REPEAT: begin
          if (rcnt == PER_LAST) begin
            rcnt_nxt = '0;
            rep_nxt  = 1'b1;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
        default: rcnt_nxt = '0;
      endcase
    end
  end

endmodule

// File: rtl/btn_cond.sv
// Five-button conditioner: shared sample-tick prescaler feeding five
// independent debounce/auto-repeat channels.
module btn_cond
  import btn_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned STABLE_CNT = 20,
  parameter int unsigned REPEAT_DLY = 500,
  parameter int unsigned REPEAT_PER = 100
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_BTN-1:0] BTN,
  output logic [NUM_BTN-1:0] BTN_LVL,
  output logic [NUM_BTN-1:0] BTN_PRS,
  output logic [NUM_BTN-1:0] BTN_REP
);

  localparam int unsigned   PW       = $clog2(SAMPLE_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  // Sample tick in the single clock where the prescaler sits at its last count
  always_comb tick = (pcnt == DIV_LAST);

  // Prescaler counting 0..SAMPLE_DIV-1 and wrapping
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_chan #(
      .STABLE_CNT(STABLE_CNT),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
    ) u_chan (
      .clk    (CLK),
      .rst    (RESET),
      .btn_raw(BTN[i]),
      .tick   (tick),
      .lvl    (BTN_LVL[i]),
      .prs    (BTN_PRS[i]),
      .rep    (BTN_REP[i])
    );
  end

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond: a per-cycle scoreboard fed by a
// behavioural model, plus directed timing checks for each scenario.
module tb_btn_cond;
  import btn_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned SC = 3;
  localparam int unsigned RD = 5;
  localparam int unsigned RP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = '0;
  logic [4:0] lvl;
  logic [4:0] prs;
  logic [4:0] rep;

  btn_cond #(
    .SAMPLE_DIV(SD),
    .STABLE_CNT(SC),
    .REPEAT_DLY(RD),
    .REPEAT_PER(RP)
  ) dut (
    .CLK    (clk),
    .RESET  (rst),
    .BTN    (btn),
    .BTN_LVL(lvl),
    .BTN_PRS(prs),
    .BTN_REP(rep)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [14:0] sb_q[$];
  logic [14:0] sb_e;
  bit          started = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural reference model
  bit [4:0] ms1, ms2, mlvl, mprs, mrep;
  int       mpc;
  int       mst[5];
  int       mmode[5];  // 0 idle, 1 waiting first repeat, 2 repeating
  int       mrc[5];

  task automatic m_reset();
    ms1 = '0; ms2 = '0; mlvl = '0; mprs = '0; mrep = '0; mpc = 0;
    for (int i = 0; i < 5; i++) begin
      mst[i] = 0; mmode[i] = 0; mrc[i] = 0;
    end
  endtask

  task automatic m_step(input logic [4:0] b);
    bit [4:0] old2;
    bit       tk;
    bit       flipped;
    old2 = ms2;
    tk   = (mpc == int'(SD) - 1);
    mpc  = (mpc + 1) % int'(SD);
    ms2  = ms1;
    ms1  = b;
    mprs = '0;
    mrep = '0;
    for (int i = 0; i < 5; i++) begin
      flipped = 0;
      if (tk) begin
        if (old2[i] != mlvl[i]) begin
          mst[i]++;
          if (mst[i] == int'(SC)) begin
            mst[i]  = 0;
            mlvl[i] = ~mlvl[i];
            flipped = 1;
            mrc[i]  = 0;
            if (mlvl[i]) begin
              mprs[i] = 1; mrep[i] = 1; mmode[i] = 1;
            end else begin
              mmode[i] = 0;
            end
          end
        end else begin
          mst[i] = 0;
        end
        if (!flipped && mmode[i] == 1) begin
          mrc[i]++;
          if (mrc[i] == int'(RD)) begin
            mrep[i] = 1; mmode[i] = 2; mrc[i] = 0;
          end
        end else if (!flipped && mmode[i] == 2) begin
          mrc[i]++;
          if (mrc[i] == int'(RP)) begin
            mrep[i] = 1; mrc[i] = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
      if (clk && started) sb_q.push_back('0);
    end else if (started) begin
      m_step(btn);
      sb_q.push_back({mlvl, mprs, mrep});
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      chk("cycle", 32'({lvl, prs, rep}), 32'(sb_e));
    end
  end

  // Observation window statistics
  int       w, prs_n, prs_at, rise_at, fall_at;
  logic [4:0] prs_v, lvl_or, rep_or;
  int       repq[$];

  task automatic win_clear();
    w = 0; prs_n = 0; prs_at = -1; rise_at = -1; fall_at = -1;
    prs_v = '0; lvl_or = '0; rep_or = '0;
    repq.delete();
  endtask

  task automatic run(input int n, input int ch);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      w++;
      if (prs != 0) begin
        prs_n++; prs_v = prs; prs_at = w;
      end
      lvl_or = lvl_or | lvl;
      rep_or = rep_or | rep;
      if (lvl[ch] && rise_at < 0) rise_at = w;
      if (!lvl[ch] && fall_at < 0) fall_at = w;
      if (rep[ch]) repq.push_back(w);
    end
  endtask

  int late;

  initial begin
    // Scenario 1: reset with all buttons held
    btn = 5'h1F;
    #2 rst = 1'b1;
    started = 1;
    #1 chk("s1_rst_outputs", 32'({lvl, prs, rep}), 32'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    win_clear();
    run(30, U);
    chk("s1_lvl", 32'(lvl), 32'h1F);
    chk("s1_prs_cycles", prs_n, 1);
    chk("s1_prs_val", 32'(prs_v), 32'h1F);
    #2 btn = '0;
    run(40, U);
    chk("s1_release", 32'(lvl), 32'h0);

    // Scenario 2: BTNC glitch shorter than the stable count
    win_clear();
    #2 btn[C] = 1'b1;
    run(8, C);
    #2 btn = '0;
    run(40, C);
    chk("s2_lvl", 32'(lvl_or), 32'h0);
    chk("s2_prs", prs_n, 0);
    chk("s2_rep", 32'(rep_or), 32'h0);

    // Scenario 3: BTNU held, press then auto-repeat cadence
    win_clear();
    #2 btn[U] = 1'b1;
    run(80, U);
    chk("s3_rise_lat_in_range", 32'(rise_at >= 11 && rise_at <= 14), 32'h1);
    chk("s3_prs_with_rise", prs_at, rise_at);
    chk("s3_nrep_ge4", 32'(repq.size() >= 4), 32'h1);
    if (repq.size() >= 4) begin
      chk("s3_rep0_with_prs", repq[0], prs_at);
      chk("s3_first_repeat_gap", repq[1] - repq[0], int'(RD * SD));
      chk("s3_repeat_gap_a", repq[2] - repq[1], int'(RP * SD));
      chk("s3_repeat_gap_b", repq[3] - repq[2], int'(RP * SD));
    end

    // Scenario 4: release BTNU while repeating
    win_clear();
    #2 btn[U] = 1'b0;
    run(40, U);
    chk("s4_fall_lat_in_range", 32'(fall_at >= 11 && fall_at <= 14), 32'h1);
    late = 0;
    foreach (repq[j]) if (repq[j] >= fall_at) late++;
    chk("s4_no_rep_after_fall", late, 0);
    chk("s4_fsm_idle", 32'(dut.g_chan[0].u_chan.state), 32'(IDLE));
    chk("s4_no_prs_on_release", prs_n, 0);

    // Scenario 5: BTNL and BTND together
    win_clear();
    #2 btn = 5'b10010;
    run(20, L);
    chk("s5_prs_cycles", prs_n, 1);
    chk("s5_prs_val", 32'(prs_v), 32'h12);
    #2 btn = '0;
    run(40, L);

    // Scenario 6: BTNR toggled every tick
    win_clear();
    for (int t = 0; t < 20; t++) begin
      #2 btn[R] = ~btn[R];
      run(4, R);
    end
    #2 btn = '0;
    run(20, R);
    chk("s6_lvl", 32'(lvl_or), 32'h0);
    chk("s6_prs", prs_n, 0);

    // Reset in the middle of repeating, button still held
    #2 btn = 5'h10;
    run(40, D);
    #2 rst = 1'b1;
    #1 chk("s7_rst_outputs", 32'({lvl, prs, rep}), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    win_clear();
    run(10, D);
    chk("s7_quiet_after_rst", 32'({prs_v, rep_or}), 32'h0);
    run(20, D);
    chk("s7_repress_cycles", prs_n, 1);
    chk("s7_repress_val", 32'(prs_v), 32'h10);

    #2 btn = '0;
    run(4, D);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
